// File: rtl/sdram_req_queue.sv
// Request FIFO and one-at-a-time scheduler in front of sdram_ctrl.
// Paces commands to controller idle plus a fixed post-command gap, and regenerates read-response strobes.
//
// state   | meaning
// IDLE    | wait for a queued request while the controller is idle, then pop it
// ISSUE   | single-cycle wr/rd pulse to the controller
// RD_WAIT | count down to the cycle where o_rd_data is valid
// GAP     | enforced quiet time before the next issue
module sdram_req_queue #(
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int Depth     = 4,
    parameter int RdLatency = 10,
    parameter int CmdGap    = 12
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [AddrWidth-1:0] i_req_addr,
    input  logic [DataWidth-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    output logic [DataWidth-1:0] o_rsp_rdata,
    output logic                 o_wr_req,
    output logic [AddrWidth-1:0] o_wr_addr,
    output logic [DataWidth-1:0] o_wr_data,
    output logic                 o_rd_req,
    output logic [AddrWidth-1:0] o_rd_addr,
    input  logic [DataWidth-1:0] i_rd_data,
    input  logic                 i_ctrl_idle,
    output logic                 o_busy
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);
    localparam int MaxCnt = (RdLatency > CmdGap) ? RdLatency : CmdGap;
    localparam int CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [CntW-1:0]     cnt, cnt_next;
    logic [PtrW-1:0]     wr_ptr, rd_ptr;
    logic [CountW-1:0]   count;
    logic                push, pop, rsp_capture;
    logic                issue_we;

    logic                 q_we   [Depth];
    logic [AddrWidth-1:0] q_addr [Depth];
    logic [DataWidth-1:0] q_data [Depth];

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign o_req_ready = ~i_rst && (count != CountW'(Depth));
    assign push        = i_req_valid && o_req_ready;
    assign o_busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            q_we[wr_ptr]   <= i_req_we;
            q_addr[wr_ptr] <= i_req_addr;
            q_data[wr_ptr] <= i_req_wdata;
        end
    end

    // Pop only ever happens from a registered non-zero count, so a push into
    // an empty queue cannot fall through in the same cycle.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CountW'(1);
                2'b01:   count <= count - CountW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pop         = 1'b0;
        rsp_capture = 1'b0;
        o_wr_req    = 1'b0;
        o_rd_req    = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && i_ctrl_idle) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_we) begin
                    o_wr_req   = 1'b1;
                    state_next = GAP;
                    cnt_next   = CntW'(CmdGap - 1);
                end else begin
                    o_rd_req   = 1'b1;
                    state_next = RD_WAIT;
                    cnt_next   = CntW'(RdLatency - 1);
                end
            end
            RD_WAIT: begin
                // cnt reaches 0 in cycle ISSUE+RdLatency, where read data is valid.
                if (cnt == '0) begin
                    rsp_capture = 1'b1;
                    state_next  = GAP;
                    cnt_next    = CntW'(CmdGap - 1);
                end else begin
                    cnt_next = cnt - CntW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CntW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_we    <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_rd_addr   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_rsp_valid <= rsp_capture;
            if (rsp_capture) o_rsp_rdata <= i_rd_data;
            if (pop) begin
                issue_we <= q_we[rd_ptr];
                if (q_we[rd_ptr]) begin
                    o_wr_addr <= q_addr[rd_ptr];
                    o_wr_data <= q_data[rd_ptr];
                end else begin
                    o_rd_addr <= q_addr[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue: scoreboard of expected issues and read
// responses, with a small controller model answering reads RdLatency cycles after the pulse.
module tb_sdram_req_queue;

    localparam int AW    = 22;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int RDL   = 10;
    localparam int GAP   = 12;
    localparam logic [DW-1:0] JUNK = 16'hDEAD;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic          clk;
    logic          i_rst, i_req_valid, i_req_we, i_ctrl_idle;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_wdata, i_rd_data;
    logic          o_req_ready, o_rsp_valid, o_wr_req, o_rd_req, o_busy;
    logic [DW-1:0] o_rsp_rdata, o_wr_data;
    logic [AW-1:0] o_wr_addr, o_rd_addr;

    sdram_req_queue #(
        .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .RdLatency(RDL), .CmdGap(GAP)
    ) dut (
        .i_sys_clk  (clk),
        .i_rst      (i_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata),
        .o_wr_req   (o_wr_req),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_req   (o_rd_req),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .i_ctrl_idle(i_ctrl_idle),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    req_t          exp_issue [$];
    logic [DW-1:0] exp_rsp   [$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] ctrl_mem  [logic [AW-1:0]];

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : 16'h0000;
    endfunction

    function automatic logic [DW-1:0] ctrl_rd(input logic [AW-1:0] a);
        return ctrl_mem.exists(a) ? ctrl_mem[a] : 16'h0000;
    endfunction

    task automatic model_push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_issue.push_back(req_t'({we, a, d}));
        if (we) model_mem[a] = d;
        else    exp_rsp.push_back(model_rd(a));
    endtask

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic push_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        while (!o_req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("push_ready", o_req_ready, 1'b1);
        if (o_req_ready) model_push(we, a, d);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_issue.size() + exp_rsp.size(), 0);
        chk("drain_busy", o_busy, 1'b0);
    endtask

    // Controller model and output monitor.
    int            cyc = 0, last_pulse = -1, pulse_count = 0, rd_cd = 0, st_cd = 0;
    logic [AW-1:0] rd_addr_lat;
    logic          exp_strobe;
    req_t          e;

    initial begin
        i_rd_data = JUNK;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                rd_cd      = 0;
                st_cd      = 0;
                last_pulse = -1;
                i_rd_data  = JUNK;
                chk("reset_outputs_zero",
                    |{o_req_ready, o_rsp_valid, o_rsp_rdata, o_wr_req, o_wr_addr,
                      o_wr_data, o_rd_req, o_rd_addr, o_busy}, 1'b0);
            end else begin
                cyc++;
                i_rd_data = JUNK;
                if (rd_cd > 0) begin
                    rd_cd--;
                    if (rd_cd == 0) i_rd_data = ctrl_rd(rd_addr_lat);
                end
                exp_strobe = 1'b0;
                if (st_cd > 0) begin
                    st_cd--;
                    if (st_cd == 0) exp_strobe = 1'b1;
                end
                chk("rsp_valid_timing", o_rsp_valid, exp_strobe);
                if (o_rsp_valid && exp_rsp.size() > 0)
                    chk("rsp_rdata", o_rsp_rdata, exp_rsp.pop_front());
                if (o_wr_req || o_rd_req) begin
                    pulse_count++;
                    chk("single_req", o_wr_req && o_rd_req, 1'b0);
                    if (last_pulse >= 0) chk("cmd_spacing", (cyc - last_pulse) >= GAP + 2, 1'b1);
                    last_pulse = cyc;
                    chk("pulse_expected", exp_issue.size() > 0, 1'b1);
                    if (exp_issue.size() > 0) begin
                        e = exp_issue.pop_front();
                        chk("pulse_type", o_wr_req, e.we);
                        if (e.we) begin
                            chk("wr_addr", o_wr_addr, e.addr);
                            chk("wr_data", o_wr_data, e.data);
                        end else begin
                            chk("rd_addr", o_rd_addr, e.addr);
                        end
                    end
                    if (o_wr_req) ctrl_mem[o_wr_addr] = o_wr_data;
                    if (o_rd_req) begin
                        rd_addr_lat = o_rd_addr;
                        rd_cd       = RDL;
                        st_cd       = RDL + 1;
                    end
                end
            end
        end
    end

    logic [AW-1:0] a0, a1, a2, a3;
    logic [AW-1:0] pool [4];
    req_t          t3_req [5];
    int            pc0, n;

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_ctrl_idle = 1'b1;
        a0 = {12'd13, 8'd5, 2'd0};
        a1 = {12'd200, 8'd17, 2'd3};
        a2 = {12'd4095, 8'd255, 2'd1};
        a3 = {12'd7, 8'd128, 2'd2};
        pool[0] = a0; pool[1] = a1; pool[2] = a2; pool[3] = a3;

        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_req_ready, 1'b1);
        chk("busy_after_reset", o_busy, 1'b0);

        // Single write: pulse two cycles after acceptance, exactly one cycle wide.
        push_req(1'b1, a0, 16'hBEEF);
        chk("t1_no_pulse_n1", o_wr_req, 1'b0);
        @(negedge clk);
        chk("t1_wr_req", o_wr_req, 1'b1);
        chk("t1_wr_addr", o_wr_addr, a0);
        chk("t1_wr_data", o_wr_data, 16'hBEEF);
        chk("t1_rd_req", o_rd_req, 1'b0);
        @(negedge clk);
        chk("t1_wr_req_one_cycle", o_wr_req, 1'b0);
        wait_drain(100);

        // Read back the same address.
        push_req(1'b0, a0, 16'h0000);
        wait_drain(100);
        chk("t2_rsp_rdata_held", o_rsp_rdata, 16'hBEEF);

        // Fill while the controller is busy; fifth request must be refused.
        t3_req[0] = req_t'({1'b1, a1, 16'h1111});
        t3_req[1] = req_t'({1'b0, a1, 16'h0000});
        t3_req[2] = req_t'({1'b1, a0, 16'h2222});
        t3_req[3] = req_t'({1'b0, a0, 16'h0000});
        t3_req[4] = req_t'({1'b1, a1, 16'h3333});
        i_ctrl_idle = 1'b0;
        pc0 = pulse_count;
        for (int i = 0; i < 5; i++) begin
            i_req_valid = 1'b1;
            i_req_we    = t3_req[i].we;
            i_req_addr  = t3_req[i].addr;
            i_req_wdata = t3_req[i].data;
            chk("t3_fill_ready", o_req_ready, i < 4);
            if (o_req_ready) model_push(t3_req[i].we, t3_req[i].addr, t3_req[i].data);
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t3_no_issue_while_busy", pulse_count - pc0, 0);
        chk("t3_busy", o_busy, 1'b1);
        chk("t3_full", o_req_ready, 1'b0);
        i_ctrl_idle = 1'b1;
        wait_drain(400);
        chk("t3_four_pulses", pulse_count - pc0, 4);

        // Simultaneous push and pop at count 2, then wrap the pointers with mixed traffic.
        i_ctrl_idle = 1'b0;
        push_req(1'b1, a2, 16'h4444);
        push_req(1'b0, a2, 16'h0000);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = a3;
        i_req_wdata = 16'h5555;
        i_ctrl_idle = 1'b1;
        chk("t4_ready_at_two", o_req_ready, 1'b1);
        if (o_req_ready) model_push(1'b1, a3, 16'h5555);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("t4_count_push_pop", dut.count, 2);
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, 3);
            push_req(1'($urandom_range(0, 1)), pool[n], 16'($urandom));
        end
        wait_drain(1000);

        // Reset while a read is in flight with more reads queued behind it.
        push_req(1'b0, a1, 16'h0000);
        n = 0;
        while (exp_issue.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_read_issued", exp_issue.size(), 0);
        push_req(1'b0, a0, 16'h0000);
        push_req(1'b0, a2, 16'h0000);
        chk("t5_busy_before", o_busy, 1'b1);
        #1;
        i_rst = 1'b1;
        exp_issue.delete();
        exp_rsp.delete();
        #1;
        chk("t5_outputs_zero_immediate",
            |{o_req_ready, o_rsp_valid, o_rsp_rdata, o_wr_req, o_wr_addr,
              o_wr_data, o_rd_req, o_rd_addr, o_busy}, 1'b0);
        repeat (RDL + 5) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_after", o_busy, 1'b0);
        chk("t5_ready_after", o_req_ready, 1'b1);
        pc0 = pulse_count;
        repeat (30) @(negedge clk);
        chk("t5_no_pulse_after_reset", pulse_count - pc0, 0);
        push_req(1'b0, a1, 16'h0000);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
